// File: rtl/i2s_lock_ctrl_pkg.sv
// Shared encodings and widths for the I2S clock-source lock supervisor.
package i2s_lock_ctrl_pkg;

  localparam int unsigned POSN_W        = 6;
  localparam int unsigned FRAME_LEN_DEF = 64;

  localparam logic [1:0] ST_LOCAL  = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_EXT    = 2'b10;
  localparam logic [1:0] ST_DRAIN  = 2'b11;

endpackage

// File: rtl/i2s_frame_meter.sv
// Frame-start detect and frame-length measurement for one bit-strobe source.
module i2s_frame_meter
  import i2s_lock_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned CW        = 8
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              en,
  input  logic [POSN_W-1:0] posn,
  output logic              wrap_c,
  output logic              good_c
);

  logic [POSN_W-1:0] prev_posn;
  logic [CW-1:0]     len_cnt;

  // A frame starts where the position falls back to zero.
  assign wrap_c = (posn == '0) && (prev_posn != '0);
  assign good_c = wrap_c && (len_cnt == CW'(FRAME_LEN));

  // Previous position, sampled every cycle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) prev_posn <= '0;
    else        prev_posn <= posn;
  end

  // Strobes since the last frame start; saturates so overlong frames read bad.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt <= '0;
    end else if (wrap_c) begin
      len_cnt <= en ? CW'(1) : '0;
    end else if (en && (len_cnt != '1)) begin
      len_cnt <= len_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_lock_ctrl.sv
// Chooses local or external I2S timing; qualifies the external source and
// switches only at frame boundaries.
module i2s_lock_ctrl
  import i2s_lock_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = FRAME_LEN_DEF,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned LOSS_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 128
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              ext_en,
  input  logic [POSN_W-1:0] ext_frame_posn,
  input  logic              local_en,
  input  logic [POSN_W-1:0] local_frame_posn,
  input  logic              force_local,
  output logic              sel_ext,
  output logic              locked,
  output logic [1:0]        state,
  output logic              frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic              ext_wrap_c;
  logic              ext_good_c;
  logic              local_wrap_c;
  logic              dead_c;
  logic [POSN_W-1:0] prev_local_posn;
  logic [CW-1:0]     dead_cnt;
  logic [CW-1:0]     good_cnt;
  logic [CW-1:0]     bad_cnt;
  logic [CW-1:0]     good_nxt;
  logic [CW-1:0]     bad_nxt;
  logic [CW-1:0]     good_inc;
  logic [CW-1:0]     bad_inc;
  logic [1:0]        state_nxt;
  logic              err_nxt;

  // External frame meter.
  i2s_frame_meter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_ext_meter (
    .ck     (ck),
    .rst_n  (rst_n),
    .en     (ext_en),
    .posn   (ext_frame_posn),
    .wrap_c (ext_wrap_c),
    .good_c (ext_good_c)
  );

  // Local side only needs the frame-start detect.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) prev_local_posn <= '0;
    else        prev_local_posn <= local_frame_posn;
  end

  assign local_wrap_c = (local_frame_posn == '0) && (prev_local_posn != '0);

  // Local strobes seen since the last external strobe.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (ext_en) begin
      dead_cnt <= '0;
    end else if (local_en && !dead_c) begin
      dead_cnt <= dead_cnt + CW'(1);
    end
  end

  assign dead_c   = (dead_cnt == CW'(TIMEOUT));
  assign good_inc = good_cnt + CW'(1);
  assign bad_inc  = bad_cnt + CW'(1);

  // State, qualification counters and registered outputs.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOCAL;
      sel_ext   <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      sel_ext   <= state_nxt[1];
      locked    <= (state_nxt == ST_EXT);
      frame_err <= err_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
    end
  end

  // Next-state logic; force_local outranks every other transition.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    err_nxt   = 1'b0;
    if (((state == ST_VERIFY) || (state == ST_EXT)) && ext_wrap_c && !ext_good_c) begin
      err_nxt = 1'b1;
    end
    case (state)
      ST_LOCAL: begin
        if (ext_wrap_c && !force_local && !dead_c) begin
          state_nxt = ST_VERIFY;
          good_nxt  = '0;
        end
      end
      ST_VERIFY: begin
        if (force_local || dead_c) begin
          state_nxt = ST_LOCAL;
        end else if (ext_wrap_c) begin
          if (ext_good_c) begin
            good_nxt = good_inc;
            if (good_inc == CW'(LOCK_FRAMES)) begin
              state_nxt = ST_EXT;
              bad_nxt   = '0;
            end
          end else begin
            good_nxt = '0;
          end
        end
      end
      ST_EXT: begin
        if (force_local || dead_c) begin
          state_nxt = ST_DRAIN;
        end else if (ext_wrap_c) begin
          if (ext_good_c) begin
            bad_nxt = '0;
          end else begin
            bad_nxt = bad_inc;
            if (bad_inc == CW'(LOSS_FRAMES)) state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (local_wrap_c) state_nxt = ST_LOCAL;
      end
      default: state_nxt = ST_LOCAL;
    endcase
  end

endmodule

// File: tb/tb_i2s_lock_ctrl.sv
// Self-checking bench for i2s_lock_ctrl: frame-accurate source generators
// feed the DUT; expectations are queued at stimulus time and popped after
// the edge that should produce them.
module tb_i2s_lock_ctrl;
  import i2s_lock_ctrl_pkg::*;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       ext_en;
  logic [5:0] ext_frame_posn;
  logic       local_en;
  logic [5:0] local_frame_posn;
  logic       force_local;
  logic       sel_ext;
  logic       locked;
  logic [1:0] state;
  logic       frame_err;

  i2s_lock_ctrl dut (
    .ck               (ck),
    .rst_n            (rst_n),
    .ext_en           (ext_en),
    .ext_frame_posn   (ext_frame_posn),
    .local_en         (local_en),
    .local_frame_posn (local_frame_posn),
    .force_local      (force_local),
    .sel_ext          (sel_ext),
    .locked           (locked),
    .state            (state),
    .frame_err        (frame_err)
  );

  always #5 ck = ~ck;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       sel;
    logic       lk;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;

  // Source generator state (bit strobe every other cycle).
  bit         ext_on = 1'b0;
  bit         ext_ph = 1'b1;
  bit         loc_ph = 1'b1;
  int         ext_idx = 0;
  int         ext_k = 64;
  int         loc_idx = 0;
  logic [5:0] prev_ext_drv = '0;
  logic [5:0] prev_loc_drv = '0;

  function automatic logic [5:0] posn_of(input int idx);
    return (idx > 63) ? 6'd63 : 6'(idx);
  endfunction

  task automatic drive();
    ext_en           = ext_on && ext_ph;
    ext_frame_posn   = posn_of(ext_idx);
    local_en         = loc_ph;
    local_frame_posn = posn_of(loc_idx);
  endtask

  task automatic advance();
    @(posedge ck);
    #1;
    if (frame_err === 1'b1) err_seen++;
    prev_ext_drv = ext_frame_posn;
    prev_loc_drv = local_frame_posn;
    if (ext_en) begin
      ext_idx++;
      if (ext_idx >= ext_k) begin
        ext_idx = 0;
        ext_k   = 64;
      end
    end
    if (local_en) begin
      loc_idx++;
      if (loc_idx >= 64) loc_idx = 0;
    end
    ext_ph = !ext_ph;
    loc_ph = !loc_ph;
    drive();
  endtask

  function automatic bit ext_wrap_pres();
    return (ext_frame_posn == 6'd0) && (prev_ext_drv != 6'd0);
  endfunction

  function automatic bit loc_wrap_pres();
    return (local_frame_posn == 6'd0) && (prev_loc_drv != 6'd0);
  endfunction

  task automatic wait_ext_wrap(input string nm);
    int n = 0;
    while (!ext_wrap_pres() && n < 400) begin
      advance();
      n++;
    end
    if (!ext_wrap_pres()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no external frame start within 400 ck", nm);
    end
  endtask

  task automatic wait_loc_wrap(input string nm);
    int n = 0;
    while (!loc_wrap_pres() && n < 400) begin
      advance();
      n++;
    end
    if (!loc_wrap_pres()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no local frame start within 400 ck", nm);
    end
  endtask

  // From LOCAL with good external frames: first wrap -> VERIFY, 4 good -> EXT.
  task automatic get_to_ext(input string nm);
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      wait_ext_wrap(nm);
      if (i == 4) begin
        n_cmp++;
        if (sel_ext !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_sel_early: sel_ext got %b want 0", nm, sel_ext);
        end
      end
      sb_q.push_back('{$sformatf("%s_wrap%0d", nm, i + 1), (i == 4) ? ST_EXT : ST_VERIFY,
                       (i == 4), (i == 4), 1'b0});
      advance();
      e = sb_q.pop_front();
      n_cmp++;
      if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
        n_bad++;
        $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
                 state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n       = 1'b0;
    force_local = 1'b0;
    drive();
    advance();
    advance();
    sb_q.push_back('{"reset", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_local_only();
    int bad_cyc = 0;
    int err0 = err_seen;
    for (int c = 0; c < 20 * 128; c++) begin
      advance();
      if (state !== ST_LOCAL || sel_ext !== 1'b0 || locked !== 1'b0) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++;
      $display("FAIL local_only_state: cycles off LOCAL got %0d want 0", bad_cyc);
    end
    n_cmp++;
    if (err_seen - err0 != 0) begin
      n_bad++;
      $display("FAIL local_only_err: frame_err pulses got %0d want 0", err_seen - err0);
    end
  endtask

  task automatic test_lock();
    int err0 = err_seen;
    ext_on  = 1'b1;
    ext_idx = 0;
    ext_k   = 64;
    drive();
    get_to_ext("lock");
    n_cmp++;
    if (err_seen - err0 != 0) begin
      n_bad++;
      $display("FAIL lock_err: frame_err pulses got %0d want 0", err_seen - err0);
    end
  endtask

  // Bad/good alternation in EXT never accumulates to LOSS_FRAMES.
  task automatic test_single_bad();
    exp_t e;
    int lens[4] = '{65, 64, 65, 64};
    ext_k = lens[0];
    for (int f = 0; f < 4; f++) begin
      wait_ext_wrap("single_bad");
      if (f < 3) ext_k = lens[f + 1];
      sb_q.push_back('{$sformatf("single_bad_f%0d", f), ST_EXT, 1'b1, 1'b1, (lens[f] != 64)});
      advance();
      e = sb_q.pop_front();
      n_cmp++;
      if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
        n_bad++;
        $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
                 state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
      end
    end
  endtask

  task automatic test_loss();
    exp_t e;
    ext_k = 65;
    for (int f = 0; f < 2; f++) begin
      wait_ext_wrap("loss");
      if (f == 0) ext_k = 65;
      sb_q.push_back('{$sformatf("loss_f%0d", f), (f == 1) ? ST_DRAIN : ST_EXT, 1'b1,
                       (f == 0), 1'b1});
      advance();
      e = sb_q.pop_front();
      n_cmp++;
      if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
        n_bad++;
        $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
                 state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
      end
    end
    wait_loc_wrap("loss_drain");
    sb_q.push_back('{"loss_drain_hold", ST_DRAIN, 1'b1, 1'b0, 1'b0});
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    sb_q.push_back('{"loss_to_local", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
  endtask

  // 3 good, one short frame, then 4 more good are needed to lock.
  task automatic test_verify_bad();
    exp_t e;
    for (int w = 0; w < 9; w++) begin
      wait_ext_wrap("verify_bad");
      if (w == 3) ext_k = 63;
      sb_q.push_back('{$sformatf("verify_bad_w%0d", w), (w == 8) ? ST_EXT : ST_VERIFY,
                       (w == 8), (w == 8), (w == 4)});
      advance();
      e = sb_q.pop_front();
      n_cmp++;
      if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
        n_bad++;
        $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
                 state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
      end
    end
  endtask

  task automatic test_force_local();
    exp_t e;
    for (int c = 0; c < 10; c++) advance();
    force_local = 1'b1;
    sb_q.push_back('{"force_ext_to_drain", ST_DRAIN, 1'b1, 1'b0, 1'b0});
    advance();
    wait_loc_wrap("force_drain");
    sb_q.push_back('{"force_drain_to_local", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    // First expectation was produced one edge after force_local rose.
    e = sb_q.pop_front();
    n_cmp++;
    if (e.st !== ST_DRAIN) begin
      n_bad++;
      $display("FAIL force_queue: order got %b want %b", e.st, ST_DRAIN);
    end
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    wait_ext_wrap("force_hold");
    sb_q.push_back('{"force_hold_local", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    force_local = 1'b0;
    wait_ext_wrap("force_release");
    sb_q.push_back('{"force_release_verify", ST_VERIFY, 1'b0, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    for (int c = 0; c < 10; c++) advance();
    force_local = 1'b1;
    sb_q.push_back('{"force_verify_to_local", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    force_local = 1'b0;
  endtask

  // External strobes stop: 128 local strobes later the source is dead.
  task automatic test_timeout();
    exp_t e;
    int n_loc = 0;
    int budget = 0;
    get_to_ext("timeout_lock");
    ext_on = 1'b0;
    drive();
    while (n_loc < 128 && budget < 1000) begin
      if (local_en) n_loc++;
      advance();
      budget++;
    end
    sb_q.push_back('{"timeout_at_128", ST_EXT, 1'b1, 1'b1, 1'b0});
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    sb_q.push_back('{"timeout_drain", ST_DRAIN, 1'b1, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    wait_loc_wrap("timeout_drain");
    sb_q.push_back('{"timeout_local", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
  endtask

  // Async reset asserted between edges while draining.
  task automatic test_reset_mid_drain();
    exp_t e;
    ext_on  = 1'b1;
    ext_idx = 0;
    ext_k   = 64;
    drive();
    get_to_ext("rst_lock");
    for (int c = 0; c < 5; c++) advance();
    force_local = 1'b1;
    sb_q.push_back('{"rst_pre_drain", ST_DRAIN, 1'b1, 1'b0, 1'b0});
    advance();
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    #2;
    rst_n = 1'b0;
    sb_q.push_back('{"rst_async", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
    force_local = 1'b0;
    advance();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) advance();
    sb_q.push_back('{"rst_after_release", ST_LOCAL, 1'b0, 1'b0, 1'b0});
    e = sb_q.pop_front();
    n_cmp++;
    if ({state, sel_ext, locked, frame_err} !== {e.st, e.sel, e.lk, e.err}) begin
      n_bad++;
      $display("FAIL %s: st/sel/lk/err got %b/%b/%b/%b want %b/%b/%b/%b", e.name,
               state, sel_ext, locked, frame_err, e.st, e.sel, e.lk, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_local_only();
    test_lock();
    test_single_bad();
    test_loss();
    test_verify_bad();
    test_force_local();
    test_timeout();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
